// File: rtl/count_uart_reporter_if.sv
// count_uart_reporter_if: reporter bus; master drives count_i/force_i, slave drives tx_o/busy_o/pending_o
interface count_uart_reporter_if #(
  parameter int COUNT_WIDTH = 8
);
  logic [COUNT_WIDTH-1:0] count_i;
  logic force_i;
  logic tx_o;
  logic busy_o;
  logic pending_o;
  modport master(output count_i, force_i, input tx_o, busy_o, pending_o);
  modport slave(input count_i, force_i, output tx_o, busy_o, pending_o);
endinterface

// File: rtl/count_uart_reporter.sv
// count_uart_reporter: sends count_i as hex+CRLF over 8N1 UART on change or force; ports clk, rst_n (sync low), bus (count_i, force_i -> tx_o, busy_o, pending_o)
module count_uart_reporter #(
  parameter int COUNT_WIDTH = 8,
  parameter int CLKS_PER_BIT = 104
) (
  input logic clk,
  input logic rst_n,
  count_uart_reporter_if.slave bus
);
  localparam int N = (COUNT_WIDTH + 3) / 4;
  localparam int SW = 4 * N;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(N + 2);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [SW-1:0] sh_q, sh_d;
  logic [COUNT_WIDTH-1:0] last_q, last_d;
  logic force_q, force_d, tx_q, tx_d, changed, go, tick, last_byte;
  logic [3:0] nib;
  logic [7:0] cur;
  assign changed = bus.count_i != last_q;
  assign go = changed | force_q | bus.force_i;
  assign tick = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign last_byte = byte_q == BW'(N + 1);
  assign nib = sh_q[SW-1 -: 4];
  assign cur = byte_q == BW'(N) ? 8'h0d : last_byte ? 8'h0a : nib < 4'd10 ? {4'h3, nib} : 8'h37 + {4'h0, nib};
  assign bus.tx_o = tx_q;
  assign bus.busy_o = state_q != IDLE;
  assign bus.pending_o = bus.busy_o & (changed | force_q);
  always_comb begin
    state_d = state_q;
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    bit_d = bit_q;
    byte_d = byte_q;
    sh_d = sh_q;
    last_d = last_q;
    tx_d = tx_q;
    force_d = force_q | bus.force_i;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (go) begin
          state_d = START;
          tx_d = 1'b0;
          byte_d = '0;
          sh_d = SW'(bus.count_i);
          last_d = bus.count_i;
          force_d = 1'b0;
        end
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d = '0;
        tx_d = cur[0];
      end
      DATA: if (tick) begin
        bit_d = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
        tx_d = bit_q == 3'd7 ? 1'b1 : cur[bit_q + 3'd1];
      end
      STOP: if (tick) begin
        state_d = last_byte ? IDLE : START;
        tx_d = last_byte;
        byte_d = byte_q + BW'(1);
        sh_d = sh_q << 4;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
      sh_q <= '0;
      last_q <= '0;
      force_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      sh_q <= sh_d;
      last_q <= last_d;
      force_q <= force_d;
      tx_q <= tx_d;
    end
  end
endmodule

// File: tb/tb_count_uart_reporter.sv
// tb_count_uart_reporter: self-checking bench for count_uart_reporter at widths 8 and 5, 4 clocks per bit
module tb_count_uart_reporter;
  localparam int CPB = 4;
  localparam int BT = 10 * CPB;
  localparam int N = 2;
  localparam int MSG = (N + 2) * BT;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  count_uart_reporter_if #(.COUNT_WIDTH(8)) b8();
  count_uart_reporter_if #(.COUNT_WIDTH(5)) b5();
  count_uart_reporter #(.COUNT_WIDTH(8), .CLKS_PER_BIT(CPB)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  count_uart_reporter #(.COUNT_WIDTH(5), .CLKS_PER_BIT(CPB)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));
  always #5 clk = ~clk;
  logic [1:0] tx_w, busy_w, pend_w, frc_w;
  logic [31:0] cnt_w [2];
  assign tx_w = {b5.tx_o, b8.tx_o};
  assign busy_w = {b5.busy_o, b8.busy_o};
  assign pend_w = {b5.pending_o, b8.pending_o};
  assign frc_w = {b5.force_i, b8.force_i};
  assign cnt_w[0] = 32'(b8.count_i);
  assign cnt_w[1] = 32'(b5.count_i);
  bit m_busy [2];
  bit m_force [2];
  int m_start [2];
  logic [31:0] m_last [2];
  logic [31:0] m_snap [2];
  logic [7:0] rxq0 [$];
  logic [7:0] rxq1 [$];
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  function automatic logic [7:0] hexc(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
  endfunction
  function automatic logic exp_tx(input int i);
    int k, b, bp;
    logic [7:0] by;
    if (!m_busy[i]) return 1'b1;
    k = cyc - m_start[i];
    b = k / BT;
    bp = (k % BT) / CPB;
    by = b == N ? 8'h0d : b == N + 1 ? 8'h0a : hexc(4'((m_snap[i] >> (4 * (N - 1 - b))) & 32'hf));
    return bp == 0 ? 1'b0 : bp == 9 ? 1'b1 : by[bp-1];
  endfunction
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] = 1'b0;
        m_last[i] = '0;
        m_force[i] = 1'b0;
      end else if (m_busy[i]) begin
        m_force[i] = m_force[i] | frc_w[i];
        if (cyc - m_start[i] == MSG) m_busy[i] = 1'b0;
      end else if (cnt_w[i] != m_last[i] || m_force[i] || frc_w[i]) begin
        m_busy[i] = 1'b1;
        m_start[i] = cyc;
        m_last[i] = cnt_w[i];
        m_snap[i] = cnt_w[i];
        m_force[i] = 1'b0;
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("tx%0d", i), 32'(tx_w[i]), 32'(exp_tx(i)));
        chk($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(m_busy[i]));
        chk($sformatf("pending%0d", i), 32'(pend_w[i]), 32'(m_busy[i] && (cnt_w[i] != m_last[i] || m_force[i])));
      end
    end
  end
  task automatic mon(input int i);
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx_w[i] === 1'b0) begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = tx_w[i];
        end
        repeat (CPB) @(negedge clk);
        chk($sformatf("stop%0d", i), 32'(tx_w[i]), 32'd1);
        if (i == 0) rxq0.push_back(b);
        else rxq1.push_back(b);
      end
    end
  endtask
  initial mon(0);
  initial mon(1);
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic set_cnt(input int i, input logic [31:0] v);
    if (i == 0) b8.count_i = v[7:0];
    else b5.count_i = v[4:0];
  endtask
  task automatic set_frc(input int i, input logic v);
    if (i == 0) b8.force_i = v;
    else b5.force_i = v;
  endtask
  task automatic check_msg(input int i, input string hx);
    logic [7:0] exp [$];
    logic [7:0] got [$];
    for (int k = 0; k < hx.len(); k++) exp.push_back(hx[k]);
    exp.push_back(8'h0d);
    exp.push_back(8'h0a);
    if (i == 0) got = rxq0;
    else got = rxq1;
    chk({hx, "_bytes"}, 32'(got.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size() && k < got.size(); k++) chk($sformatf("%s_byte%0d", hx, k), 32'(got[k]), 32'(exp[k]));
    rxq0.delete();
    rxq1.delete();
  endtask
  task automatic run_msg(input int i, input int a1, input logic [31:0] v1, input int a2, input logic [31:0] v2, input int fa, input string nm);
    int len, w;
    w = 0;
    while (!busy_w[i] && w < 100) begin
      tick(1);
      w++;
    end
    len = 0;
    while (busy_w[i] && len < 1000) begin
      tick(1);
      len++;
      if (len == a1 + 1) chk({nm, "_pend"}, 32'(pend_w[i]), 32'd1);
      if (len == a1) set_cnt(i, v1);
      if (len == a2) set_cnt(i, v2);
      set_frc(i, len == fa);
    end
    chk({nm, "_len"}, 32'(len), 32'd160);
    check_msg(i, nm);
  endtask
  initial begin
    b8.count_i = '0;
    b5.count_i = '0;
    b8.force_i = 1'b0;
    b5.force_i = 1'b0;
    tick(3);
    chk_en = 1'b1;
    chk("rst_tx", 32'(b8.tx_o), 32'd1);
    chk("rst_busy", 32'(b8.busy_o), 32'd0);
    chk("rst_pend", 32'(b8.pending_o), 32'd0);
    rst_n = 1'b1;
    tick(200);
    chk("idle_tx", 32'(b8.tx_o), 32'd1);
    chk("idle_rx", 32'(rxq0.size()), 32'd0);
    set_cnt(0, 32'h3a);
    tick(1);
    chk("lat_tx", 32'(b8.tx_o), 32'd0);
    chk("lat_busy", 32'(b8.busy_o), 32'd1);
    run_msg(0, 20, 32'h3b, 40, 32'h3c, -1, "3A");
    run_msg(0, 20, 32'h40, 40, 32'h3c, -1, "3C");
    tick(50);
    chk("back_busy", 32'(b8.busy_o), 32'd0);
    chk("back_rx", 32'(rxq0.size()), 32'd0);
    set_frc(0, 1'b1);
    tick(1);
    set_frc(0, 1'b0);
    chk("force_busy", 32'(b8.busy_o), 32'd1);
    run_msg(0, -1, 0, -1, 0, -1, "3C");
    set_cnt(0, 32'h55);
    set_frc(0, 1'b1);
    tick(1);
    set_frc(0, 1'b0);
    run_msg(0, -1, 0, -1, 0, 30, "55");
    run_msg(0, -1, 0, -1, 0, -1, "55");
    tick(20);
    chk("once_busy", 32'(b8.busy_o), 32'd0);
    chk("once_rx", 32'(rxq0.size()), 32'd0);
    set_cnt(1, 32'h1f);
    run_msg(1, -1, 0, -1, 0, -1, "1F");
    set_cnt(1, 32'h0);
    run_msg(1, -1, 0, -1, 0, -1, "00");
    set_cnt(0, 32'h77);
    tick(51);
    chk("mid_busy", 32'(b8.busy_o), 32'd1);
    rst_n = 1'b0;
    tick(1);
    chk("mrst_tx", 32'(b8.tx_o), 32'd1);
    chk("mrst_busy", 32'(b8.busy_o), 32'd0);
    chk("mrst_pend", 32'(b8.pending_o), 32'd0);
    set_cnt(0, 32'h05);
    tick(50);
    rxq0.delete();
    rxq1.delete();
    rst_n = 1'b1;
    run_msg(0, -1, 0, -1, 0, -1, "05");
    tick(20);
    chk("end_rx", 32'(rxq0.size() + rxq1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
